serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned subtractor: computes `d = a - b` with borrow-out `bo`, processing one bit per clock, LSB first, under a start/done handshake. It is the inverse of the lab's combinational 4-bit adder and shares its operand/result conventions (`a`, `b`, result, carry/borrow flag). It sits beside the adder in the combinational-design labs as the first sequential arithmetic block, and is reused later by repeated-subtraction dividers.

## Interface
- `N`, default 4: operand and result width in bits. Legal range is N ≥ 2.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a subtraction. Sampled only when the block is idle.
- `a`  in  N: minuend, unsigned. Sampled on the accepting edge.
- `b`  in  N: subtrahend, unsigned. Sampled on the accepting edge.
- `d`  out  N: difference, `(a - b) mod 2^N`. Registered.
- `bo`  out  1: borrow-out, 1 iff `a < b`. Registered.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when `d`/`bo` are updated.

## Operation
- FSM has 2 states, IDLE and SHIFT.
- IDLE with `start=1`: latch `a` and `b` into shift registers, clear internal borrow `br`, clear bit counter, go to SHIFT, set `busy=1`.
- IDLE with `start=0`: hold. `d` and `bo` keep the last result.
- SHIFT, each cycle:
  - Take `x = a_sh[0]` and `y = b_sh[0]`.
  - Compute `diff = x^y^br` and `br_next = (~x&y) | (~(x^y)&br)`.
  - Shift `diff` into the result register at the MSB. Shift `a_sh` and `b_sh` right by one.
  - Increment the counter.
- SHIFT, bit N-1 (counter = N-1): write the final result to `d`, write `br_next` to `bo`, pulse `done=1`, drop `busy`, return to IDLE.
- `start` while busy: ignored. Changes on `a`/`b` while busy have no effect.
- `start` during the done cycle: accepted, because the FSM is already in IDLE. This gives back-to-back operation with no gap cycle.
- Arithmetic is unsigned and wraps modulo 2^N. There is no overflow flag; `bo` is the only status.
- Reset (any time, including mid-operation): FSM to IDLE, operation aborted, all outputs and internal registers forced to 0.

## Timing
- Reset values: `d=0`, `bo=0`, `busy=0`, `done=0`.
- Latency, with accepting edge E0:
  - `busy` is high from E0 to E_N.
  - `d`, `bo` and `done` are valid after edge E_N, so N cycles from start to result.
  - `done` is high for exactly one cycle.
- Throughput: one operation per N cycles.
- `d`/`bo` change only at a done edge or at reset. They are stable at all other times.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `arith_pkg` holds:
  - state encoding localparams `S_IDLE=1'b0` and `S_SHIFT=1'b1`;
  - default width `ARITH_W=4`, which is shared with the adder.
- Counter width is `$clog2(N)`.
- One sub-module, `full_subtractor`: a combinational 1-bit cell with inputs `x`, `y`, `bi` and outputs `diff`, `bo`. It is instantiated once in the datapath.
- The top level holds the FSM, the shift registers, the counter and the output registers.

## Test plan
- Basic subtraction: `a=9`, `b=3`, pulse `start` → after 4 cycles `d=6`, `bo=0`, `done` pulsed once.
- Underflow: `a=3`, `b=9` → `d=4'b1010`, `bo=1`. Also `a=0`, `b=1` → `d=15`, `bo=1`.
- Exhaustive: all 256 (`a`, `b`) pairs → `{bo,d}` equals `{a<b, (a-b)&4'hF}`; `busy` high for exactly 4 cycles each time.
- Back-to-back: assert `start` in the done cycle with `a=15`, `b=15` after a `12-5` operation → first result `d=7`, `bo=0`; second result `d=0`, `bo=0` exactly 4 cycles later.
- Start while busy: re-pulse `start` with new operands during cycle 2 of an operation → ignored; the original result is produced and no extra `done` occurs.
- Reset mid-operation: assert `rst_n=0` in cycle 2 → `d`, `bo`, `busy` and `done` are all 0 immediately. After release, `start` with `a=5`, `b=2` → `d=3`, `bo=0`.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: FSM state encoding and the default operand
// width used by both the combinational adder and the serial subtractor.
package arith_pkg;

    localparam int   ARITH_W = 4;
    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    typedef enum logic {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(
    parameter int N = arith_pkg::ARITH_W
) ();

    // Handshake: start is a request that is accepted on any rising edge where
    // busy is low (a/b are captured on that edge). There is no backpressure
    // on results: done is a one-cycle strobe, and d/bo hold until the next done.
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic         bo;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b,
        input  d, bo, busy, done
    );

    modport slave (
        input  start, a, b,
        output d, bo, busy, done
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bi, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Result d/bo is registered and only updated on the done edge.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int N = ARITH_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus,
    output state_e               dbg_state
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    a_sh_q, a_sh_d;
    logic [N-1:0]    b_sh_q, b_sh_d;
    logic [N-1:0]    res_q, res_d;
    logic [N-1:0]    d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            br_q, br_d;
    logic            bo_q, bo_d;
    logic            done_q, done_d;
    logic            diff_bit;
    logic            br_next;

    full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bi   (br_q),
        .diff (diff_bit),
        .bo   (br_next)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Difference bits enter at the MSB so the LSB lands at bit 0 after N shifts.
                res_d  = {diff_bit, res_q[N-1:1]};
                a_sh_d = {1'b0, a_sh_q[N-1:1]};
                b_sh_d = {1'b0, b_sh_q[N-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    d_d     = {diff_bit, res_q[N-1:1]};
                    bo_d    = br_next;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            done_q  <= done_d;
        end
    end

    assign bus.d     = d_q;
    assign bus.bo    = bo_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q == ST_SHIFT);
    assign dbg_state = state_q;

endmodule
